trainer: RTL and testbench
==========================

Name: trainer

Overview:
- Sequencer that drives one `node` instance through forward passes and, in training mode, backward passes over a stream of labelled samples.
- Fetches each sample and its target, issues the forward operand vector, and collects the activation.
- Forwards the activation downstream, then computes the error `target - result` and feeds it to the node's backward input.
- Drains the node's backward-propagated errors and counts completed samples until the programmed count is reached. Sits between the sample source and a single node.

Parameters:
- N, 2, number of node inputs (width of the operand vector and of the backprop vector)
- COUNT_W, 16, width of the sample counter
- SUM_W, 24, width of the saturating absolute-error accumulator

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  1 = train, 0 = inference; latched on start
- count  in  COUNT_W  samples in the run; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- error_sum  out  SUM_W  saturating sum of |error| since last start
- sample_valid / sample_ready  in / out  1  sample stream handshake
- sample_data  in  N*8  operand vector
- sample_target  in  8  unsigned Q0.8 target
- node_train  out  1  latched mode while busy, 0 otherwise
- node_forward_valid / node_forward_ready  out / in  1  to node input_forward
- node_forward_data  out  N*8  latched operand vector
- node_result_valid / node_result_ready  in / out  1  from node output_forward
- node_result_data  in  8  node activation
- node_error_valid / node_error_ready  out / in  1  to node input_backward
- node_error_data  out  16  signed error
- node_backprop_valid / node_backprop_ready  in / out  1  from node output_backward
- node_backprop_data  in  N*16  consumed and discarded
- result_valid / result_ready  out / in  1  downstream activation stream
- result_data  out  8  activation

Behaviour:
- Reset (asynchronous, any state): state = IDLE. All valid/ready outputs, busy, done and node_train are 0. Counter = 0, error_sum = 0, data registers = 0.
- All valid outputs and ready outputs are registered or decoded purely from state. No combinational path from any input valid to any output ready.
- IDLE:
  - On start: latch mode and count, clear error_sum, go to FETCH.
  - If count == 0: go to FIN instead.
- FETCH: sample_ready = 1. On handshake, latch sample_data and sample_target, then go to ISSUE.
- ISSUE: node_forward_valid = 1 with the latched data. On node_forward_ready, go to COLLECT.
- COLLECT: node_result_ready = 1. On handshake:
  - latch the result;
  - error = signed 16-bit of {8'b0,target} - {8'b0,result}, range -255..255;
  - error_sum += |error|, saturating at 2^SUM_W-1;
  - go to EMIT.
- EMIT: result_valid = 1. On result_ready:
  - if the latched mode is 1, go to ERROR;
  - otherwise go to NEXT.
- ERROR: node_error_valid = 1 with the latched error. On node_error_ready, go to DRAIN.
- DRAIN: node_backprop_ready = 1. On node_backprop_valid, go to NEXT.
- NEXT: decrement the counter.
  - If the counter was 1, go to FIN.
  - Otherwise go to FETCH.
- FIN: done = 1 for exactly one cycle, then go to IDLE.
- Latency, inference mode, zero-wait partners: 5 cycles per sample (FETCH, ISSUE, COLLECT, EMIT, NEXT), excluding node compute time. Train mode adds 2 cycles (ERROR, DRAIN).
- start is ignored while busy.
- mode and count changes while busy have no effect.
- Every handshake whose valid is asserted holds its data stable until accepted.
- node_train is held for the whole run, so the node samples it correctly in its FWD state.
- sample_valid while not in FETCH is not consumed.
- Reset mid-run abandons the sample; the node must be reset together with the trainer.

Decomposition:
- Shared package machina_pkg holds:
  - `sample_t` (logic [7:0]);
  - `error_t` (logic signed [15:0]);
  - the trainer state enum;
  - function `compute_error(target, result)`, returning error_t;
  - function `sat_add(sum, abs_err)`.
- No sub-module. The datapath is a handful of registers. The node is instantiated by the enclosing top, not inside trainer.

Test Plan:
- Inference, count=3, node stub returns 0x80 each time → three result beats of 0x80, no node_error_valid ever, done pulses once, busy falls the cycle after done.
- Train, count=1, target=0xC0, result 0x40 → node_error_data = 0x0080, one backprop beat drained, error_sum = 128.
- Train, target=0x00, result=0xFF → node_error_data = 0xFF01 (-255), error_sum = 255.
- count=0 with start → no sample_ready, done pulses the cycle after FIN is entered, busy high for exactly 1 cycle.
- Backpressure: random deassertion of node_forward_ready, result_ready and node_error_ready → data stable while valid is high, no lost or duplicated beats over 100 samples, error_sum matches the model.
- Reset asserted asynchronously in ERROR → all outputs 0 immediately. A new start then runs a full sample correctly.
- Saturation: SUM_W=8, two samples with |error| of 200 each → error_sum = 255.

Source files
------------

// File: rtl/machina_pkg.sv
// Shared types and helpers for the trainer sequencer.
//   sample_t        : 8-bit unsigned Q0.8 sample / activation
//   error_t         : signed 16-bit error, range -255..255
//   trainer_state_t : trainer FSM states
//   compute_error   : target - result as a signed 16-bit value
//   abs_error       : magnitude of an error_t
//   sat_add         : saturating add of a magnitude onto a running sum
package machina_pkg;

  typedef logic [7:0]         sample_t;
  typedef logic signed [15:0] error_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_COLLECT,
    ST_EMIT,
    ST_ERROR,
    ST_DRAIN,
    ST_NEXT,
    ST_FIN
  } trainer_state_t;

  // Both operands are zero-extended, so the difference always fits in 16 bits.
  function automatic error_t compute_error(input sample_t target, input sample_t result);
    return $signed({8'h00, target}) - $signed({8'h00, result});
  endfunction

  function automatic logic [15:0] abs_error(input error_t err);
    return err[15] ? 16'(-err) : 16'(err);
  endfunction

  // The sum is carried in 32 bits so one helper serves any accumulator width up
  // to 32; the caller passes its own all-ones ceiling as the saturation limit.
  function automatic logic [31:0] sat_add(input logic [31:0] sum,
                                          input logic [15:0] abs_err,
                                          input logic [31:0] limit);
    logic [32:0] wide;
    wide = {1'b0, sum} + {17'b0, abs_err};
    if (wide > {1'b0, limit}) begin
      return limit;
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/trainer.sv
// trainer: sequences one node through forward (and in train mode, backward)
// passes over a stream of labelled samples.
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   start, mode, count      : run control; mode/count latched when a run starts
//   busy, done              : run status; done pulses once at the end of a run
//   error_sum               : saturating sum of |target - result| since last start
//   sample_*                : sample source (operand vector + target)
//   node_train              : latched mode for the node, 0 when idle
//   node_forward_*          : operand vector to the node
//   node_result_*           : activation from the node
//   node_error_*            : signed error to the node's backward input
//   node_backprop_*         : node's backward output, drained and discarded
//   result_*                : activation forwarded downstream
module trainer
  import machina_pkg::*;
#(
  parameter int N       = 2,
  parameter int COUNT_W = 16,
  parameter int SUM_W   = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   error_sum,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [N*8-1:0]     sample_data,
  input  logic [7:0]         sample_target,
  output logic               node_train,
  output logic               node_forward_valid,
  input  logic               node_forward_ready,
  output logic [N*8-1:0]     node_forward_data,
  input  logic               node_result_valid,
  output logic               node_result_ready,
  input  logic [7:0]         node_result_data,
  output logic               node_error_valid,
  input  logic               node_error_ready,
  output logic [15:0]        node_error_data,
  input  logic               node_backprop_valid,
  output logic               node_backprop_ready,
  input  logic [N*16-1:0]    node_backprop_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [7:0]         result_data
);

  localparam logic [31:0] SUM_MAX = 32'((64'd1 << SUM_W) - 64'd1);

  trainer_state_t     state;
  logic [COUNT_W-1:0] count_q;
  sample_t            target_q;
  error_t             err_now;

  // The backprop vector carries nothing the trainer needs; it is only drained.
  logic backprop_unused;
  assign backprop_unused = ^node_backprop_data;

  assign err_now = compute_error(target_q, node_result_data);

  // Single FSM. Every valid/ready/status output is a register that is set on
  // the transition into the state that owns it and cleared on the way out, so
  // no input valid ever reaches an output ready combinationally. node_train
  // doubles as the latched mode for the whole run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      busy                <= 1'b0;
      done                <= 1'b0;
      node_train          <= 1'b0;
      sample_ready        <= 1'b0;
      node_forward_valid  <= 1'b0;
      node_result_ready   <= 1'b0;
      result_valid        <= 1'b0;
      node_error_valid    <= 1'b0;
      node_backprop_ready <= 1'b0;
      count_q             <= '0;
      error_sum           <= '0;
      target_q            <= '0;
      node_forward_data   <= '0;
      node_error_data     <= '0;
      result_data         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            node_train <= mode;
            count_q    <= count;
            error_sum  <= '0;
            if (count == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state        <= ST_FETCH;
              sample_ready <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (sample_valid) begin
            node_forward_data  <= sample_data;
            target_q           <= sample_target;
            sample_ready       <= 1'b0;
            node_forward_valid <= 1'b1;
            state              <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (node_forward_ready) begin
            node_forward_valid <= 1'b0;
            node_result_ready  <= 1'b1;
            state              <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (node_result_valid) begin
            result_data       <= node_result_data;
            node_error_data   <= err_now;
            error_sum         <= SUM_W'(sat_add(32'(error_sum), abs_error(err_now), SUM_MAX));
            node_result_ready <= 1'b0;
            result_valid      <= 1'b1;
            state             <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (node_train) begin
              node_error_valid <= 1'b1;
              state            <= ST_ERROR;
            end else begin
              state <= ST_NEXT;
            end
          end
        end

        ST_ERROR: begin
          if (node_error_ready) begin
            node_error_valid    <= 1'b0;
            node_backprop_ready <= 1'b1;
            state               <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (node_backprop_valid) begin
            node_backprop_ready <= 1'b0;
            state               <= ST_NEXT;
          end
        end

        // count_q still holds the pre-decrement value here, so 1 means the
        // sample just finished was the last one.
        ST_NEXT: begin
          count_q <= count_q - 1'b1;
          if (count_q == COUNT_W'(1)) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            sample_ready <= 1'b1;
            state        <= ST_FETCH;
          end
        end

        ST_FIN: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          node_train <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trainer.sv
// Self-checking bench for trainer. A behavioural environment plays sample
// source, node stub and downstream sink with random stalls; expected beats and
// error sums come from per-sample arrays and plain integer arithmetic.
module tb_trainer;

  localparam int N       = 2;
  localparam int COUNT_W = 16;
  localparam int SUM_W   = 24;
  localparam int SAT_W   = 8;
  localparam int MAXS    = 128;

  logic               clock;
  logic               reset;
  logic               start;
  logic               mode;
  logic [COUNT_W-1:0] count;
  logic               busy, done;
  logic [SUM_W-1:0]   error_sum;
  logic               sample_valid, sample_ready;
  logic [N*8-1:0]     sample_data;
  logic [7:0]         sample_target;
  logic               node_train;
  logic               node_forward_valid, node_forward_ready;
  logic [N*8-1:0]     node_forward_data;
  logic               node_result_valid, node_result_ready;
  logic [7:0]         node_result_data;
  logic               node_error_valid, node_error_ready;
  logic [15:0]        node_error_data;
  logic               node_backprop_valid, node_backprop_ready;
  logic [N*16-1:0]    node_backprop_data;
  logic               result_valid, result_ready;
  logic [7:0]         result_data;

  // Outputs of the narrow-accumulator copy, which runs in lockstep on the same inputs.
  logic               s_busy, s_done, s_sample_ready, s_node_train;
  logic               s_fwd_valid, s_res_ready, s_err_valid, s_bp_ready, s_result_valid;
  logic [SAT_W-1:0]   s_error_sum;
  logic [N*8-1:0]     s_fwd_data;
  logic [15:0]        s_err_data;
  logic [7:0]         s_result_data;

  trainer #(.N(N), .COUNT_W(COUNT_W), .SUM_W(SUM_W)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .count(count),
    .busy(busy), .done(done), .error_sum(error_sum),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_target(sample_target),
    .node_train(node_train),
    .node_forward_valid(node_forward_valid), .node_forward_ready(node_forward_ready),
    .node_forward_data(node_forward_data),
    .node_result_valid(node_result_valid), .node_result_ready(node_result_ready),
    .node_result_data(node_result_data),
    .node_error_valid(node_error_valid), .node_error_ready(node_error_ready),
    .node_error_data(node_error_data),
    .node_backprop_valid(node_backprop_valid), .node_backprop_ready(node_backprop_ready),
    .node_backprop_data(node_backprop_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
  );

  trainer #(.N(N), .COUNT_W(COUNT_W), .SUM_W(SAT_W)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .count(count),
    .busy(s_busy), .done(s_done), .error_sum(s_error_sum),
    .sample_valid(sample_valid), .sample_ready(s_sample_ready),
    .sample_data(sample_data), .sample_target(sample_target),
    .node_train(s_node_train),
    .node_forward_valid(s_fwd_valid), .node_forward_ready(node_forward_ready),
    .node_forward_data(s_fwd_data),
    .node_result_valid(node_result_valid), .node_result_ready(s_res_ready),
    .node_result_data(node_result_data),
    .node_error_valid(s_err_valid), .node_error_ready(node_error_ready),
    .node_error_data(s_err_data),
    .node_backprop_valid(node_backprop_valid), .node_backprop_ready(s_bp_ready),
    .node_backprop_data(node_backprop_data),
    .result_valid(s_result_valid), .result_ready(result_ready), .result_data(s_result_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Per-sample stimulus and the node stub's scripted activations
  logic [N*8-1:0] smp_data [MAXS];
  logic [7:0]     smp_tgt  [MAXS];
  logic [7:0]     smp_act  [MAXS];
  int n_smp, src_idx, fwd_idx, res_given, res_out_idx, err_idx, bp_given, done_cnt;
  int stall_pct;
  bit hold_err;
  bit exp_mode;
  logic [15:0] last_err;
  logic pv_f, pa_f, pv_r, pa_r, pv_e, pa_e;

  typedef struct {
    logic        mode;
    logic [7:0]  tgt;
    logic [7:0]  act;
    logic [15:0] exp_err;
    int          exp_sum;
    int          exp_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit go();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  function automatic logic [15:0] exp_err(input int i);
    return 16'(int'(smp_tgt[i % MAXS]) - int'(smp_act[i % MAXS]));
  endfunction

  function automatic int model_sum(input int n, input int limit);
    int s, d;
    s = 0;
    for (int i = 0; i < n; i++) begin
      d = int'(smp_tgt[i]) - int'(smp_act[i]);
      s += (d < 0) ? -d : d;
      if (s > limit) s = limit;
    end
    return s;
  endfunction

  task automatic reset_env();
    n_smp = 0; src_idx = 0; fwd_idx = 0; res_given = 0; res_out_idx = 0;
    err_idx = 0; bp_given = 0; done_cnt = 0; last_err = '0; hold_err = 1'b0;
    pv_f = 0; pa_f = 0; pv_r = 0; pa_r = 0; pv_e = 0; pa_e = 0;
  endtask

  task automatic load(input int i, input logic [N*8-1:0] d, input logic [7:0] t, input logic [7:0] a);
    smp_data[i] = d; smp_tgt[i] = t; smp_act[i] = a;
  endtask

  task automatic hold_check(input string nm, input logic v, input logic hs, inout logic pv, inout logic pa);
    if (pv && !pa) checkOutput(nm, 64'(v), 64'd1);
    pv = v;
    pa = hs;
  endtask

  // One environment step per falling edge: drive partner inputs for the next
  // rising edge, then account for the handshakes that edge will complete.
  task automatic env_cycle();
    logic hs;
    if (reset) begin
      sample_valid = 0; node_forward_ready = 0; node_result_valid = 0;
      result_ready = 0; node_error_ready = 0; node_backprop_valid = 0;
      return;
    end
    sample_valid        = (src_idx < n_smp) && go();
    sample_data         = smp_data[src_idx % MAXS];
    sample_target       = smp_tgt[src_idx % MAXS];
    node_forward_ready  = go();
    node_result_valid   = (res_given < fwd_idx) && go();
    node_result_data    = smp_act[res_given % MAXS];
    result_ready        = go();
    node_error_ready    = !hold_err && go();
    node_backprop_valid = (bp_given < err_idx) && go();
    node_backprop_data  = $urandom;

    if (sample_valid && sample_ready) src_idx++;

    hs = node_forward_valid && node_forward_ready;
    if (node_forward_valid) checkOutput("fwd_data", 64'(node_forward_data), 64'(smp_data[fwd_idx % MAXS]));
    hold_check("fwd_hold_valid", node_forward_valid, hs, pv_f, pa_f);
    if (hs) fwd_idx++;

    if (node_result_valid && node_result_ready) res_given++;

    hs = result_valid && result_ready;
    if (result_valid) checkOutput("result_data", 64'(result_data), 64'(smp_act[res_out_idx % MAXS]));
    hold_check("result_hold_valid", result_valid, hs, pv_r, pa_r);
    if (hs) res_out_idx++;

    hs = node_error_valid && node_error_ready;
    if (node_error_valid) checkOutput("error_data", 64'(node_error_data), 64'(exp_err(err_idx)));
    hold_check("error_hold_valid", node_error_valid, hs, pv_e, pa_e);
    if (hs) begin
      last_err = node_error_data;
      err_idx++;
    end

    if (node_backprop_valid && node_backprop_ready) bp_given++;
    if (busy) checkOutput("node_train", 64'(node_train), 64'(exp_mode));
    if (done) done_cnt++;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      env_cycle();
    end
  end

  task automatic applyStimulus(input logic m, input logic [COUNT_W-1:0] c);
    @(negedge clock);
    start = 1'b1; mode = m; count = c;
    @(posedge clock);
    #1;
    start = 1'b0; mode = 1'($urandom); count = COUNT_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    $display("[TB] FAIL wait_done: no done within %0d cycles", budget);
    errors++;
    checks++;
  endtask

  task automatic check_run(input string tag, input int n, input bit m, input int sum, input int sat);
    repeat (2) @(negedge clock);
    checkOutput({tag, "_src"}, 64'(src_idx), 64'(n));
    checkOutput({tag, "_fwd"}, 64'(fwd_idx), 64'(n));
    checkOutput({tag, "_results"}, 64'(res_out_idx), 64'(n));
    checkOutput({tag, "_errors"}, 64'(err_idx), m ? 64'(n) : 64'd0);
    checkOutput({tag, "_backprop"}, 64'(bp_given), m ? 64'(n) : 64'd0);
    checkOutput({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, "_sum"}, 64'(error_sum), 64'(sum));
    checkOutput({tag, "_sat_sum"}, 64'(s_error_sum), 64'(sat));
  endtask

  initial begin
    bit ok;
    int busy_cyc, done_cyc, sr_cyc;

    vecs[0] = '{1'b1, 8'hC0, 8'h40, 16'h0080, 128, 128};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 16'hFF01, 255, 255};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 16'h00FF, 255, 255};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h0000, 0, 0};
    vecs[4] = '{1'b1, 8'h01, 8'h02, 16'hFFFF, 1, 1};
    vecs[5] = '{1'b0, 8'h10, 8'h20, 16'h0000, 16, 16};

    start = 0; mode = 0; count = '0; stall_pct = 0; exp_mode = 0;
    sample_valid = 0; sample_data = '0; sample_target = '0;
    node_forward_ready = 0; node_result_valid = 0; node_result_data = '0;
    node_error_ready = 0; node_backprop_valid = 0; node_backprop_data = '0; result_ready = 0;
    reset_env();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_sample_ready", 64'(sample_ready), 0);
    checkOutput("rst_fwd_valid", 64'(node_forward_valid), 0);
    checkOutput("rst_result_valid", 64'(result_valid), 0);
    checkOutput("rst_error_valid", 64'(node_error_valid), 0);
    checkOutput("rst_error_sum", 64'(error_sum), 0);
    reset = 1'b0;

    // Inference, three samples, node always answers 0x80; a second start mid-run is ignored.
    $display("[TB] inference count=3");
    reset_env();
    for (int i = 0; i < 3; i++) load(i, N*8'($urandom), 8'($urandom), 8'h80);
    n_smp = 3; exp_mode = 0;
    applyStimulus(1'b0, 16'd3);
    repeat (3) @(negedge clock);
    start = 1'b1; mode = 1'b1; count = 16'd9;
    @(negedge clock);
    start = 1'b0;
    wait_done(500, ok);
    checkOutput("inf_busy_in_done", 64'(busy), 64'd1);
    @(negedge clock);
    checkOutput("inf_busy_after_done", 64'(busy), 64'd0);
    checkOutput("inf_done_width", 64'(done), 64'd0);
    check_run("inf3", 3, 1'b0, model_sum(3, 32'hFFFFFF), model_sum(3, 255));

    // Single-sample directed vectors
    for (int v = 0; v < 6; v++) begin
      $display("[TB] vector %0d", v);
      reset_env();
      load(0, N*8'($urandom), vecs[v].tgt, vecs[v].act);
      n_smp = 1; exp_mode = vecs[v].mode;
      applyStimulus(vecs[v].mode, 16'd1);
      wait_done(200, ok);
      check_run("vec", 1, vecs[v].mode, vecs[v].exp_sum, vecs[v].exp_sat);
      checkOutput("vec_last_err", 64'(last_err), 64'(vecs[v].exp_err));
    end

    // count = 0: straight to FIN, no sample consumed
    $display("[TB] count=0");
    reset_env();
    load(0, 16'h1234, 8'h55, 8'h66);
    n_smp = 1; exp_mode = 0;
    applyStimulus(1'b0, 16'd0);
    busy_cyc = 0; done_cyc = 0; sr_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      busy_cyc += int'(busy); done_cyc += int'(done); sr_cyc += int'(sample_ready);
      @(posedge clock);
      #1;
    end
    checkOutput("zero_busy_cycles", 64'(busy_cyc), 64'd1);
    checkOutput("zero_done_cycles", 64'(done_cyc), 64'd1);
    checkOutput("zero_sample_ready", 64'(sr_cyc), 64'd0);
    checkOutput("zero_src_consumed", 64'(src_idx), 64'd0);

    // Saturation of the 8-bit accumulator: two |error| = 200 samples
    $display("[TB] saturation");
    reset_env();
    load(0, 16'hAAAA, 8'hC8, 8'h00);
    load(1, 16'h5555, 8'h00, 8'hC8);
    n_smp = 2; exp_mode = 1;
    applyStimulus(1'b1, 16'd2);
    wait_done(300, ok);
    check_run("sat", 2, 1'b1, 400, 255);

    // Asynchronous reset while waiting in ERROR, then a clean run
    $display("[TB] reset in ERROR");
    reset_env();
    load(0, 16'hBEEF, 8'h90, 8'h10);
    n_smp = 1; exp_mode = 1; hold_err = 1'b1;
    applyStimulus(1'b1, 16'd1);
    for (int k = 0; k < 100 && !node_error_valid; k++) @(negedge clock);
    checkOutput("rerr_reached_error", 64'(node_error_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rerr_busy", 64'(busy), 0);
    checkOutput("rerr_error_valid", 64'(node_error_valid), 0);
    checkOutput("rerr_node_train", 64'(node_train), 0);
    checkOutput("rerr_bp_ready", 64'(node_backprop_ready), 0);
    checkOutput("rerr_error_sum", 64'(error_sum), 0);
    checkOutput("rerr_error_data", 64'(node_error_data), 0);
    checkOutput("rerr_result_data", 64'(result_data), 0);
    checkOutput("rerr_fwd_data", 64'(node_forward_data), 0);
    reset_env();
    @(negedge clock);
    #2 reset = 1'b0;
    load(0, 16'h0F0F, 8'h30, 8'h50);
    n_smp = 1; exp_mode = 1;
    applyStimulus(1'b1, 16'd1);
    wait_done(200, ok);
    check_run("rerr_after", 1, 1'b1, 32, 32);
    checkOutput("rerr_after_err", 64'(last_err), 64'hFFE0);

    // Random train run with backpressure on every partner
    $display("[TB] random train x100");
    reset_env();
    for (int i = 0; i < 100; i++) load(i, N*8'($urandom), 8'($urandom), 8'($urandom));
    n_smp = 100; exp_mode = 1; stall_pct = 40;
    applyStimulus(1'b1, 16'd100);
    wait_done(20000, ok);
    check_run("rnd_train", 100, 1'b1, model_sum(100, 32'hFFFFFF), model_sum(100, 255));

    // Random inference run
    $display("[TB] random inference x40");
    reset_env();
    for (int i = 0; i < 40; i++) load(i, N*8'($urandom), 8'($urandom), 8'($urandom));
    n_smp = 40; exp_mode = 0; stall_pct = 50;
    applyStimulus(1'b0, 16'd40);
    wait_done(10000, ok);
    check_run("rnd_inf", 40, 1'b0, model_sum(40, 32'hFFFFFF), model_sum(40, 255));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
